// File: rtl/dac_ramp_shaper.sv
`default_nettype none
// ============================================================================
// Module  : dac_ramp_shaper
// Purpose : Per-channel DAC amplitude ramp (up / hold / down) with a
//           two-stage signed scaling datapath.
// Revision: 1.0
// ============================================================================
module dac_ramp_shaper (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        ramping_enable,
    input  logic        start_ramp_down,
    input  logic [31:0] ramp_step,
    input  logic [15:0] dac_in,
    output logic [15:0] dac_out,
    output logic [15:0] ramp_factor,
    output logic [2:0]  ramp_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UP   = 3'd1,
        ST_HOLD = 3'd2,
        ST_DOWN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [31:0] FULL = 32'h8000_0000;

    logic [1:0]         sync_q, sync_d;
    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [15:0]        prod_q, prod_d;
    logic [15:0]        dout_q, dout_d;
    logic [32:0]        sum;
    logic signed [32:0] prod_full;

    // Reset release must pass two flops before the ramp may leave IDLE.
    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum     = {1'b0, acc_q} + {1'b0, ramp_step};
        if (sync_q[1]) begin
            case (state_q)
                ST_IDLE: begin
                    if (ramping_enable) begin
                        state_d = ST_UP;
                        acc_d   = 32'd0;
                    end else begin
                        acc_d   = FULL;
                    end
                end
                ST_UP: begin
                    if (start_ramp_down) begin
                        state_d = ST_DOWN;
                    end else if (sum >= {1'b0, FULL}) begin
                        state_d = ST_HOLD;
                        acc_d   = FULL;
                    end else begin
                        acc_d   = sum[31:0];
                    end
                end
                ST_HOLD: begin
                    acc_d = FULL;
                    if (start_ramp_down) begin
                        state_d = ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (acc_q <= ramp_step) begin
                        state_d = ST_DONE;
                        acc_d   = 32'd0;
                    end else begin
                        acc_d   = acc_q - ramp_step;
                    end
                end
                ST_DONE: begin
                    acc_d = 32'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = 32'd0;
                end
            endcase
        end
    end

    // Unity is 0x8000 in Q1.15, so bits [30:15] of the product are the sample.
    always_comb begin
        prod_full = $signed(dac_in) * $signed({1'b0, acc_q[31:16]});
        prod_d    = 16'(prod_full >>> 15);
        dout_d    = prod_q;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q  <= 2'b00;
            state_q <= ST_IDLE;
            acc_q   <= 32'd0;
            prod_q  <= 16'd0;
            dout_q  <= 16'd0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            dout_q  <= dout_d;
        end
    end

    assign ramp_factor = acc_q[31:16];
    assign ramp_state  = state_q;
    assign dac_out     = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_ramp_shaper.sv
`default_nettype none
// ============================================================================
// Module  : tb_dac_ramp_shaper
// Purpose : Directed + randomized bench for dac_ramp_shaper against a
//           cycle-level behavioural model of the ramp and scaling path.
// Revision: 1.0
// ============================================================================
module tb_dac_ramp_shaper;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        ramping_enable;
    logic        start_ramp_down;
    logic [31:0] ramp_step;
    logic [15:0] dac_in;
    logic [15:0] dac_out;
    logic [15:0] ramp_factor;
    logic [2:0]  ramp_state;

    localparam longint FULL = 64'h8000_0000;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int          m_state;
    longint      m_acc;
    int          m_sync;
    logic [15:0] m_prod;
    logic [15:0] m_dout;

    dac_ramp_shaper dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .ramping_enable  (ramping_enable),
        .start_ramp_down (start_ramp_down),
        .ramp_step       (ramp_step),
        .dac_in          (dac_in),
        .dac_out         (dac_out),
        .ramp_factor     (ramp_factor),
        .ramp_state      (ramp_state)
    );

    always #4 clk = ~clk;

    function automatic logic [15:0] scale(input logic [15:0] d, input logic [15:0] f);
        longint r;
        r = (longint'($signed(d)) * longint'(f)) >>> 15;
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_acc   = 0;
        m_sync  = 0;
        m_prod  = 16'd0;
        m_dout  = 16'd0;
    endtask

    task automatic fsm_step();
        longint s;
        case (m_state)
            0: if (ramping_enable) begin m_state = 1; m_acc = 0; end
               else m_acc = FULL;
            1: if (start_ramp_down) m_state = 3;
               else begin
                   s = m_acc + longint'(ramp_step);
                   if (s >= FULL) begin m_acc = FULL; m_state = 2; end
                   else m_acc = s;
               end
            2: begin m_acc = FULL; if (start_ramp_down) m_state = 3; end
            3: if (m_acc <= longint'(ramp_step)) begin m_acc = 0; m_state = 4; end
               else m_acc = m_acc - longint'(ramp_step);
            default: m_acc = 0;
        endcase
    endtask

    task automatic compare_all();
        logic [15:0] mf;
        mf = m_acc[31:16];
        check("state",  32'(ramp_state),  32'(m_state));
        check("factor", 32'(ramp_factor), 32'(mf));
        check("dout",   32'(dac_out),     32'(m_dout));
    endtask

    // One clock: model advances with the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (!aresetn) begin
            model_reset();
        end else begin
            m_dout = m_prod;
            m_prod = scale(dac_in, m_acc[31:16]);
            if (m_sync >= 2) fsm_step();
            if (m_sync < 2) m_sync++;
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_state", 32'(ramp_state), 32'd0);
        check("rst_dout",  32'(dac_out),    32'd0);
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic run_count(input int want, output int n);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (32'(ramp_state) == 32'(want)) n++;
            else break;
        end
    endtask

    initial begin
        int n;
        aresetn         = 1'b0;
        ramping_enable  = 1'b0;
        start_ramp_down = 1'b0;
        ramp_step       = 32'h0800_0000;
        dac_in          = 16'($urandom);
        model_reset();
        #3;
        compare_all();
        @(posedge clk);
        #1;
        do_reset();

        // Pass-through in IDLE, full-scale negative sample.
        for (int i = 0; i < 4; i++) begin dac_in = 16'($urandom); tick(); end
        check("idle_factor", 32'(ramp_factor), 32'h8000);
        dac_in = 16'h8000;
        tick(); tick(); tick();
        check("pass_neg", 32'(dac_out), 32'h8000);
        for (int i = 0; i < 6; i++) begin start_ramp_down = ~start_ramp_down; tick(); end
        start_ramp_down = 1'b0;
        check("idle_ignores_down", 32'(ramp_state), 32'd0);

        // Ramp up with step 2^27.
        ramping_enable = 1'b1;
        dac_in         = 16'd20000;
        run_count(1, n);
        check("up_len", 32'(n), 32'd16);
        check("hold_reached", 32'(ramp_state), 32'd2);
        tick(); tick();
        check("hold_dout", 32'(dac_out), 32'd20000);
        ramping_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin dac_in = 16'($urandom); tick(); end
        check("hold_ignores_enable", 32'(ramp_state), 32'd2);

        // Ramp down from HOLD.
        start_ramp_down = 1'b1;
        run_count(3, n);
        check("down_len", 32'(n), 32'd16);
        start_ramp_down = 1'b0;
        tick(); tick();
        check("done_state", 32'(ramp_state), 32'd4);
        check("done_dout",  32'(dac_out),    32'd0);

        // Reset mid-UP, restart, then request down at 0x3000.
        ramping_enable = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin dac_in = 16'($urandom); tick(); end
        check("mid_up", 32'(ramp_state), 32'd1);
        do_reset();
        for (int i = 0; i < 40 && ramp_factor != 16'h3000; i++) begin
            dac_in = 16'($urandom);
            tick();
        end
        check("reach_3000", 32'(ramp_factor), 32'h3000);
        start_ramp_down = 1'b1;
        run_count(3, n);
        check("down_from_3000", 32'(n), 32'd6);
        start_ramp_down = 1'b0;

        // Saturating step and underflow-free down.
        ramp_step = 32'h7FFF_FFFF;
        do_reset();
        tick(); tick();
        run_count(1, n);
        check("sat_up_len", 32'(n), 32'd2);
        ramping_enable = 1'b0;
        tick(); tick();
        check("sat_hold", 32'(ramp_state), 32'd2);
        ramp_step       = 32'hF000_0000;
        start_ramp_down = 1'b1;
        run_count(3, n);
        check("big_down_len", 32'(n), 32'd1);
        check("big_down_done", 32'(ramp_factor), 32'd0);
        start_ramp_down = 1'b0;

        // Randomized episodes.
        for (int e = 0; e < 6; e++) begin
            ramp_step       = 32'($urandom_range(32'h0100_0000, 32'h2000_0000));
            ramping_enable  = 1'b1;
            start_ramp_down = 1'b0;
            do_reset();
            for (int i = 0; i < 90; i++) begin
                dac_in = 16'($urandom);
                if (i > 6) ramping_enable = 1'($urandom);
                start_ramp_down = ($urandom_range(0, 19) == 0);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
